// File: rtl/vpg_pattern_check.sv
// Receive-side checker for the vpg video stream: rebuilds coordinates, measures frame geometry
// and, when VPG_CHECK_PIXELS_EN is defined, compares every active pixel against the colour-scale pattern.
//
// state | meaning
// IDLE  | waiting for the first VS boundary; the leading frame is partial and is not reported
// FRAME | each boundary latches the frame results and restarts the counters
module vpg_pattern_check #(
    parameter int ERR_W = 16
) (
    input  logic             pixel_clk,
    input  logic             reset,
    input  logic             vid_de,
    input  logic             vid_hs,
    input  logic             vid_vs,
    input  logic [7:0]       vid_r,
    input  logic [7:0]       vid_g,
    input  logic [7:0]       vid_b,
    input  logic [11:0]      exp_width,
    input  logic [11:0]      exp_height,
    input  logic             clr_stats,
    output logic             frame_done,
    output logic             frame_ok,
    output logic             locked,
    output logic [11:0]      meas_width,
    output logic [11:0]      meas_height,
    output logic [ERR_W-1:0] pix_err_cnt,
    output logic [ERR_W-1:0] bad_frame_cnt
);

    typedef enum logic {IDLE, FRAME} state_t;

    state_t state_q, state_d;
    logic   de_q, de_prev_q, vs_q, vs_prev_q, clr_q, hs_unused_q;
    logic   bnd_q, latch_d, pass_d, restart;
    logic   de_fall, bnd;
    logic   [11:0] x_cnt_q, y_cnt_q, line_w_q;
    logic   w_incons_q;
    logic   [ERR_W-1:0] err_acc;

    logic             frame_done_q, frame_ok_q, locked_q;
    logic [11:0]      meas_w_q, meas_h_q;
    logic [ERR_W-1:0] pix_err_q, bad_q;

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            de_q        <= 1'b0;
            de_prev_q   <= 1'b0;
            vs_q        <= 1'b1;
            vs_prev_q   <= 1'b1;
            hs_unused_q <= 1'b1;
            clr_q       <= 1'b0;
            bnd_q       <= 1'b0;
        end else begin
            de_q        <= vid_de;
            de_prev_q   <= de_q;
            vs_q        <= vid_vs;
            vs_prev_q   <= vs_q;
            hs_unused_q <= vid_hs;
            clr_q       <= clr_stats;
            bnd_q       <= bnd & ~clr_q;
        end
    end

    assign bnd     = vs_prev_q & ~vs_q;
    assign de_fall = de_prev_q & ~de_q;
    // Counters restart one cycle after the edge detect, once the pipeline has drained.
    assign restart = bnd_q | clr_q;

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            x_cnt_q    <= '0;
            y_cnt_q    <= '0;
            line_w_q   <= '0;
            w_incons_q <= 1'b0;
        end else if (restart) begin
            x_cnt_q    <= '0;
            y_cnt_q    <= '0;
            line_w_q   <= '0;
            w_incons_q <= 1'b0;
        end else begin
            if (de_q)
                x_cnt_q <= x_cnt_q + {11'd0, x_cnt_q != 12'hFFF};
            else if (de_fall)
                x_cnt_q <= '0;
            if (de_fall) begin
                line_w_q <= x_cnt_q;
                y_cnt_q  <= y_cnt_q + {11'd0, y_cnt_q != 12'hFFF};
                if (y_cnt_q != 12'd0 && x_cnt_q != line_w_q)
                    w_incons_q <= 1'b1;
            end
        end
    end

`ifdef VPG_CHECK_PIXELS_EN
    logic [7:0]       r_q, g_q, b_q, s;
    logic [11:0]      q_h, half_h, q3_h;
    logic [23:0]      exp_rgb;
    logic             border, mismatch;
    logic [ERR_W-1:0] err_acc_q;

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
            g_q <= '0;
            b_q <= '0;
        end else begin
            r_q <= vid_r;
            g_q <= vid_g;
            b_q <= vid_b;
        end
    end

    assign s      = x_cnt_q[7:0];
    assign q_h    = exp_height >> 2;
    assign half_h = exp_height >> 1;
    assign q3_h   = q_h + half_h;
    assign border = (x_cnt_q == 12'd0) || (x_cnt_q + 12'd1 == exp_width) ||
                    (y_cnt_q == 12'd0) || (y_cnt_q + 12'd1 == exp_height);

    always_comb begin
        exp_rgb = {s, s, s};
        if (border)
            exp_rgb = 24'hFFFFFF;
        else if (y_cnt_q < q_h)
            exp_rgb = {s, 16'h0000};
        else if (y_cnt_q < half_h)
            exp_rgb = {8'h00, s, 8'h00};
        else if (y_cnt_q < q3_h)
            exp_rgb = {16'h0000, s};
    end

    assign mismatch = de_q && ({r_q, g_q, b_q} != exp_rgb);

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset)
            err_acc_q <= '0;
        else if (restart)
            err_acc_q <= '0;
        else if (mismatch && !(&err_acc_q))
            err_acc_q <= err_acc_q + ERR_W'(1);
    end

    assign err_acc = err_acc_q;
`else
    logic rgb_unused;
    assign rgb_unused = ^{vid_r, vid_g, vid_b};
    assign err_acc    = '0;
`endif

    assign pass_d = (err_acc == '0) && (line_w_q == exp_width) &&
                    (y_cnt_q == exp_height) && !w_incons_q;

    always_comb begin
        state_d = state_q;
        latch_d = 1'b0;
        if (clr_q)
            state_d = IDLE;
        else if (bnd_q) begin
            if (state_q == IDLE)
                state_d = FRAME;
            else
                latch_d = 1'b1;
        end
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            locked_q     <= 1'b0;
            meas_w_q     <= '0;
            meas_h_q     <= '0;
            pix_err_q    <= '0;
            bad_q        <= '0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= latch_d;
            if (clr_q) begin
                frame_ok_q <= 1'b0;
                locked_q   <= 1'b0;
                bad_q      <= '0;
            end else if (latch_d) begin
                meas_w_q   <= line_w_q;
                meas_h_q   <= y_cnt_q;
                pix_err_q  <= err_acc;
                frame_ok_q <= pass_d;
                locked_q   <= pass_d & frame_ok_q;
                if (!pass_d && !(&bad_q))
                    bad_q <= bad_q + ERR_W'(1);
            end
        end
    end

    assign frame_done    = frame_done_q;
    assign frame_ok      = frame_ok_q;
    assign locked        = locked_q;
    assign meas_width    = meas_w_q;
    assign meas_height   = meas_h_q;
    assign pix_err_cnt   = pix_err_q;
    assign bad_frame_cnt = bad_q;

endmodule

// File: doc/vpg_pattern_check.md
# vpg_pattern_check

Receive-side checker for the video pattern generator output stream. Consumes DE/HS/VS/RGB at pixel rate, rebuilds pixel coordinates, measures active width/height per frame and compares every active pixel against the expected colour-scale pattern. Sits on the loopback or capture path in the vpg subsystem and reports per-frame status to the control logic.

## Interface
Parameters:
- `ERR_W`, default 16: width of the error counters.

Ports:
- `pixel_clk` in 1: pixel clock; every element is sampled on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `vid_de` in 1: active-video enable.
- `vid_hs` in 1: horizontal sync, active-low, idles high. Passed through for monitoring only.
- `vid_vs` in 1: vertical sync, active-low, idles high.
- `vid_r`, `vid_g`, `vid_b` in 8 each: pixel colour.
- `exp_width`, `exp_height` in 12 each: expected active size. Must be held static while in use.
- `clr_stats` in 1: synchronous clear of statistics and lock.
- `frame_done` out 1: one-cycle pulse when a frame's results are latched.
- `frame_ok` out 1: last frame passed all checks.
- `locked` out 1: two or more consecutive passing frames.
- `meas_width`, `meas_height` out 12 each: last frame's measured size.
- `pix_err_cnt` out ERR_W: mismatched pixels in the last frame, saturating.
- `bad_frame_cnt` out ERR_W: failing frames since reset or clear, saturating.

## Operation
- **Input stage S1.** Register all inputs. Edge detection compares S1 against the previous S1 value.
- **Frame boundary.** A falling edge of `vid_vs`: S1 low, previous S1 high.
- **FSM.**
  - `IDLE` (reset value): the first boundary moves to `FRAME` and reports nothing, because the leading frame is partial.
  - `FRAME`: each boundary latches the results, pulses `frame_done` and restarts the counters.
  - `clr_stats` returns the FSM to `IDLE` and clears `bad_frame_cnt`, `locked` and `frame_ok`.
- **Coordinates.**
  - `x_cnt` increments on each cycle with DE high. It clears on a DE falling edge.
  - `y_cnt` increments on each DE falling edge. It clears at a boundary.
  - On each DE falling edge, capture `x_cnt` as `line_w`. If `line_w` differs from the previous line in the same frame, set sticky `w_incons`.
- **Expected pixel** for (x, y), with W = `exp_width` and H = `exp_height`:
  - Border: x==0, x+1==W, y==0 or y+1==H gives FF/FF/FF.
  - Otherwise let s = x[7:0] and q = H>>2, with all arithmetic at 12 bits:
    - y < q gives {s, 00, 00}.
    - y < H>>1 gives {00, s, 00}.
    - y < q+(H>>1) gives {00, 00, s}.
    - Otherwise gives {s, s, s}.
- **Compare.** Compare each DE-high pixel in S2. A mismatch increments the frame error accumulator, which saturates at all-ones.
- **Latch at boundary.**
  - `meas_width` takes the last `line_w`.
  - `meas_height` takes `y_cnt`.
  - `pix_err_cnt` takes the accumulator.
- **Pass condition.** `frame_ok` is set when all of these hold:
  - the accumulator is 0;
  - `meas_width` == `exp_width`;
  - `meas_height` == `exp_height`;
  - `w_incons` is clear.
- **Statistics.**
  - A failing frame increments `bad_frame_cnt` (saturating) and clears `locked`.
  - `locked` sets on the second consecutive passing frame.
- **Counter overflow.** `x_cnt` and `y_cnt` saturate at 4095; no wrap.
- **Ignored conditions.**
  - DE high while VS is low is not flagged.
  - `vid_hs` does not affect counting.

## Timing
- **Reset values:**
  - all outputs 0;
  - FSM `IDLE`;
  - counters 0;
  - S1 registers: `vid_vs`/`vid_hs` 1, all others 0.
- **`frame_done` timing.** Goes high exactly 2 cycles after the `pixel_clk` edge that first samples `vid_vs` low. `frame_ok`, `locked`, the `meas_*` outputs and both counters update on that same cycle and hold until the next pulse.
- **Pixel compare latency.** 2 cycles: S1 register, then S2 compare/accumulate.
- **Required blanking.** At least 2 DE-low cycles between the last active pixel and the VS falling edge, so the pipeline drains before the latch. The generator guarantees this.
- **`clr_stats` timing.** Sampled with priority over a coincident boundary. Outputs clear on the next cycle, and no `frame_done` is issued for that boundary.
- **Reset during a frame.** Aborts immediately. The next boundary is treated as the first.

## Configuration
- **`VPG_CHECK_PIXELS_EN` defined:**
  - the pixel compare path and accumulator are built;
  - `frame_ok` includes the zero-error term.
- **`VPG_CHECK_PIXELS_EN` undefined:**
  - no compare logic is built;
  - `pix_err_cnt` is tied to 0;
  - `frame_ok` depends on geometry and `w_incons` only;
  - the RGB inputs are unused.

## Test plan
- **Clean stream.** Generator 16x8, `exp` = 16x8, 3 frames → no pulse on the first boundary. Then 2 pulses, each with `meas` 16/8, `pix_err_cnt` 0 and `frame_ok` 1. `locked` is 1 after the second pulse.
- **Pixel fault.** Force the pixel at (5,1) to 00/00/00 (expected 05/00/00) in one frame → that frame reports `pix_err_cnt` 1, `frame_ok` 0, `locked` 0 and `bad_frame_cnt` 1. The next clean frame gives `frame_ok` 1.
- **Line-width fault.** One line with 15 active pixels, `exp_width` 16 → `w_incons` is set and `frame_ok` is 0. Also feed a 640x480 stream against `exp` 640x481 → `meas_height` 480 and `frame_ok` 0.
- **Saturation.** Send 70000 mismatching pixels in one frame with `ERR_W` 16 → `pix_err_cnt` 16'hFFFF.
- **Async events.**
  - Assert `reset` mid-frame → all outputs are 0 within the same cycle, and the first subsequent boundary gives no pulse.
  - Assert `clr_stats` on a boundary cycle → no pulse, and `bad_frame_cnt` is 0.
- **Macro undefined.** Same stimulus as the pixel-fault case → `pix_err_cnt` 0 and `frame_ok` 1.
